// File: rtl/arb_req_agent.sv
// Requester-side agent for a 4-way round-robin arbiter: four client FIFOs feed
// request lines, and granted words are forwarded through one registered valid/ready output.
module arb_req_agent #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    output logic [3:0]            in_ready,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic                  req0,
    output logic                  req1,
    output logic                  req2,
    output logic                  req3,
    input  logic [2:0]            gnt_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    output logic                  err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [4][DEPTH];
    logic [AW-1:0]     wr_ptr_q [4];
    logic [AW-1:0]     wr_ptr_d [4];
    logic [AW-1:0]     rd_ptr_q [4];
    logic [AW-1:0]     rd_ptr_d [4];
    logic [CW-1:0]     cnt_q [4];
    logic [CW-1:0]     cnt_d [4];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_src_q, out_src_d;
    logic              err_q, err_d;

    logic [3:0] full, empty, req, push, pop;
    logic       can_load, gnt_hit, gnt_err;
    logic [1:0] gsel;

    // Requests come from registered occupancy and out_ready only, so gnt_id never
    // loops back combinationally into req.
    always_comb begin
        can_load = !out_valid_q || out_ready;
        for (int k = 0; k < 4; k++) begin
            full[k]     = (cnt_q[k] == CW'(DEPTH));
            empty[k]    = (cnt_q[k] == '0);
            req[k]      = !rst && !empty[k] && can_load;
            in_ready[k] = !rst && !full[k];
            push[k]     = in_valid[k] && !rst && !full[k];
        end
        gsel    = gnt_id[1:0];
        gnt_hit = !gnt_id[2] && req[gsel];
        if (gnt_id[2]) begin
            gnt_err = (gsel != 2'd0) || (req != 4'b0000);
        end else begin
            gnt_err = !req[gsel];
        end
        pop = gnt_hit ? (4'b0001 << gsel) : 4'b0000;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_ptr_d[k] = push[k] ? wr_ptr_q[k] + 1'b1 : wr_ptr_q[k];
            rd_ptr_d[k] = pop[k]  ? rd_ptr_q[k] + 1'b1 : rd_ptr_q[k];
            case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
                2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
                default: cnt_d[k] = cnt_q[k];
            endcase
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (gnt_hit) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[gsel][rd_ptr_q[gsel]];
            out_src_d   = gsel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        err_d = err_q || gnt_err;
    end

    // Storage carries no reset; emptiness is tracked solely by the counters.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            err_q       <= err_d;
        end
    end

    assign req0      = req[0];
    assign req1      = req[1];
    assign req2      = req[2];
    assign req3      = req[3];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// Bench for arb_req_agent: directed scenarios plus random traffic, checked against
// a queue-based model and a behavioural round-robin arbiter.
module tb_arb_req_agent;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          in_valid;
    logic [3:0]          in_ready;
    logic [4*DATA_W-1:0] in_data;
    logic                req0, req1, req2, req3;
    logic [2:0]          gnt_id;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_src;
    logic                err;

    always #5 clk = ~clk;

    arb_req_agent #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req0      (req0),
        .req1      (req1),
        .req2      (req2),
        .req3      (req3),
        .gnt_id    (gnt_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one queue per port, the output register, sticky error, arbiter pointer.
    logic [DATA_W-1:0] mq [4][$];
    bit                m_ov  = 1'b0;
    logic [DATA_W-1:0] m_od  = '0;
    logic [1:0]        m_os  = 2'd0;
    bit                m_err = 1'b0;
    int                rr_ptr = 0;
    bit                arb_mode = 1'b1;
    logic [2:0]        forced_gnt = 3'd4;
    logic [3:0]        m_req;

    function automatic logic [2:0] rr_pick(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            int p;
            p = (rr_ptr + i) % 4;
            if (r[p]) return 3'(p);
        end
        return 3'd4;
    endfunction

    task automatic cycle();
        logic [3:0] exp_rdy;
        logic [3:0] was_full;
        bit         can_load;
        int         g;
        can_load = !m_ov || out_ready;
        for (int k = 0; k < 4; k++) begin
            m_req[k]   = !rst && (mq[k].size() > 0) && can_load;
            exp_rdy[k] = !rst && (mq[k].size() < DEPTH);
        end
        gnt_id = arb_mode ? rr_pick(m_req) : forced_gnt;
        #1;
        check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_val("req", 32'({req3, req2, req1, req0}), 32'(m_req));
        check_val("out_valid", 32'(out_valid), 32'(m_ov));
        check_val("out_data", 32'(out_data), 32'(m_od));
        check_val("out_src", 32'(out_src), 32'(m_os));
        check_val("err", 32'(err), 32'(m_err));
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
            m_ov = 0; m_od = '0; m_os = 2'd0; m_err = 0; rr_ptr = 0;
        end else begin
            for (int k = 0; k < 4; k++) was_full[k] = (mq[k].size() == DEPTH);
            g = int'(gnt_id);
            if (g < 4 && m_req[g]) begin
                m_od   = mq[g].pop_front();
                m_os   = 2'(g);
                m_ov   = 1;
                rr_ptr = (g + 1) % 4;
            end else begin
                if (g != 4 || m_req != 4'b0000) m_err = 1;
                if (out_ready) m_ov = 0;
            end
            for (int k = 0; k < 4; k++)
                if (in_valid[k] && !was_full[k]) mq[k].push_back(in_data[k*DATA_W +: DATA_W]);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push1(input int port, input logic [DATA_W-1:0] d);
        in_valid = 4'b0001 << port;
        in_data[port*DATA_W +: DATA_W] = d;
        cycle();
        in_valid = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b0000; in_data = '0; out_ready = 1'b1; gnt_id = 3'd4;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(5);

        // Mid-stream reset with three words queued behind a stalled output.
        out_ready = 1'b0;
        push1(3, 8'h31); push1(3, 8'h32); push1(3, 8'h33); push1(3, 8'h34);
        rst = 1'b1; cycle(); rst = 1'b0;
        out_ready = 1'b1;
        run(2);

        // Single word on port 0 through the arbiter.
        push1(0, 8'hA0);
        run(3);

        // Preload two words per port behind a held output, then release.
        out_ready = 1'b0;
        push1(1, 8'h10);
        for (int r = 0; r < 2; r++) begin
            in_valid = 4'b1111;
            for (int k = 0; k < 4; k++) in_data[k*DATA_W +: DATA_W] = 8'(16*k + r + 8'h40);
            cycle();
        end
        in_valid = 4'b0000;
        out_ready = 1'b1;
        run(12);

        // Overfill port 2 while the output is held.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push1(2, 8'(8'hC0 + i));
        run(2);
        out_ready = 1'b1;
        run(8);

        // Stall with ports 1 and 3 pending, then release.
        out_ready = 1'b0;
        push1(0, 8'h5A); push1(1, 8'h61); push1(3, 8'h63); push1(1, 8'h62);
        run(4);
        out_ready = 1'b1;
        run(8);

        // Protocol errors forced from the bench side.
        arb_mode = 1'b0;
        forced_gnt = 3'd6; cycle();
        forced_gnt = 3'd2; cycle();
        forced_gnt = 3'd4; run(3);
        arb_mode = 1'b1;
        push1(1, 8'h77);
        arb_mode = 1'b0; forced_gnt = 3'd4; cycle();
        arb_mode = 1'b1; run(3);
        rst = 1'b1; cycle(); rst = 1'b0;
        run(2);

        // Random traffic with occasional rogue grants and resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            arb_mode  = ($urandom_range(0, 99) != 0);
            forced_gnt = 3'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; arb_mode = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        run(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
